io_serializer: RTL and testbench
================================

IO_SERIALIZER -- requirements
Module: io_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: number of clk cycles each serial bit is held; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rs  input  1  reset; synchronous, active-high.
REQ-004 din  input  8  parallel word from the upstream 8-bit multi-mode register output.
REQ-005 ld  input  1  load request; sampled on the rising edge of clk.
REQ-006 g2b  input  1  when 1 at load, din is treated as Gray code and converted to binary before transmission.
REQ-007 txd  output  1  serial data line; idle high.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 FSM states are IDLE, START, DATA, PARITY (only when PARITY_EN is defined) and STOP, all registered.
REQ-011 In IDLE with ld=1 and rs=0, the block captures the converted word into the shift register at that edge and enters START; busy is 1 from the next cycle.
REQ-012 ld outside IDLE is ignored, with no effect on the frame or on the captured word.
REQ-013 Gray conversion: b[7]=din[7], b[i]=b[i+1]^din[i] for i=6..0; with g2b=0, b=din; g2b is sampled only at the load edge.
REQ-014 Each state holds txd constant for exactly CLKS_PER_BIT cycles, timed by a baud counter that is cleared on every state entry.
REQ-015 txd values: START=0; DATA=b[0] first through b[7] last, 8 bit periods, 3-bit bit index wraps 7->0 on exit; PARITY=XOR of b[7:0] (even parity); STOP=1; IDLE=1.
REQ-016 After the last STOP cycle the FSM returns to IDLE; busy=0 and done=1 for exactly that first IDLE cycle.
REQ-017 ld=1 in the done cycle is accepted, so back-to-back frames are separated by exactly one idle-high cycle.
REQ-018 Frame length from load edge to done is 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with PARITY_EN).

Reset
REQ-019 On rs=1 at a clk edge: state=IDLE, txd=1, busy=0, done=0, baud counter=0, bit index=0, shift register=8'h00.
REQ-020 rs takes priority over ld in the same cycle; the load is discarded.
REQ-021 rs mid-frame aborts the frame immediately; no done pulse is produced for the aborted frame.

Configuration
REQ-022 Macro IO_SERIALIZER_PARITY_EN: when defined, the PARITY state is inserted between DATA and STOP and the frame is 11 bits.
REQ-023 Without IO_SERIALIZER_PARITY_EN, DATA is followed directly by STOP, the frame is 10 bits, and no parity logic is synthesized.

Verification (CLKS_PER_BIT=4)
REQ-024 Basic frame: din=8'hA5, g2b=0, ld pulsed one cycle, no parity -> txd=0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; busy high 40 cycles; one done pulse.
REQ-025 Gray conversion: din=8'h0F, g2b=1 -> data bits transmitted are those of 8'h0A (LSB first 0,1,0,1,0,0,0,0).
REQ-026 Parity: with IO_SERIALIZER_PARITY_EN defined, din=8'h07 -> parity bit=1 for 4 cycles before stop; frame is 44 cycles. With din=8'hA5 -> parity bit=0.
REQ-027 Busy load and back-to-back: ld=1 held continuously with din=8'h3C, and din switched to 8'hFF mid-frame -> the first frame is 8'h3C intact; exactly one txd=1 idle cycle coincident with done; the next frame carries the din present at the done cycle.
REQ-028 Reset mid-frame: rs=1 for one cycle at cycle 15 of an 8'hA5 frame -> next cycle txd=1, busy=0, done=0; no done for the aborted frame; a fresh ld then starts a complete, correct frame.

Source files
------------

// File: rtl/io_serializer.sv
// io_serializer: 8-bit parallel-to-serial UART-style transmitter with optional Gray->binary
//   conversion at load. Frame = start(0), 8 data bits LSB first, [even parity], stop(1).
// Latency: txd drives the start bit the cycle after the load edge; done pulses
//   10*CLKS_PER_BIT cycles after the load edge (11*CLKS_PER_BIT with parity).
// Backpressure: none; ld is only honoured in IDLE (including the done cycle) and ignored otherwise.
// Ports: clk (clock), rs (sync active-high reset), din[7:0] (word), ld (load request),
//   g2b (treat din as Gray code), txd (serial out, idle high), busy (frame active),
//   done (one-cycle completion pulse).
// Build option: define IO_SERIALIZER_PARITY_EN to insert an even-parity bit before stop.
module io_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [7:0] din,
  input  logic       ld,
  input  logic       g2b,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LP_LAST = 8'(CLKS_PER_BIT - 1);

`ifdef IO_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t     r_state, w_state;
  logic [7:0] r_baud,  w_baud;
  logic [2:0] r_bit,   w_bit;
  logic [7:0] r_shift, w_shift;
  logic       r_txd,   w_txd;
  logic       r_busy,  w_busy;
  logic       r_done,  w_done;
  logic [7:0] w_bin;
  logic [7:0] w_word;
  logic       w_last;

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_bin[i] = ^(din >> i);
    end
  end

  assign w_word = g2b ? w_bin : din;
  assign w_last = (r_baud == LP_LAST);

  // The shift register rotates rather than shifts, so after eight data bits it holds
  // the captured word again and parity can be taken straight from it.
  always_comb begin
    w_state = r_state;
    w_baud  = r_baud + 8'd1;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_txd   = 1'b1;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud = 8'd0;
        w_busy = 1'b0;
        if (ld) begin
          w_state = S_START;
          w_shift = w_word;
          w_txd   = 1'b0;
          w_busy  = 1'b1;
        end
      end
      S_START: begin
        w_txd = 1'b0;
        if (w_last) begin
          w_state = S_DATA;
          w_baud  = 8'd0;
          w_txd   = r_shift[0];
        end
      end
      S_DATA: begin
        w_txd = r_shift[0];
        if (w_last) begin
          w_baud  = 8'd0;
          w_bit   = r_bit + 3'd1;
          w_shift = {r_shift[0], r_shift[7:1]};
          w_txd   = r_shift[1];
          if (r_bit == 3'd7) begin
`ifdef IO_SERIALIZER_PARITY_EN
            w_state = S_PARITY;
            w_txd   = ^r_shift;
`else
            w_state = S_STOP;
            w_txd   = 1'b1;
`endif
          end
        end
      end
`ifdef IO_SERIALIZER_PARITY_EN
      S_PARITY: begin
        w_txd = ^r_shift;
        if (w_last) begin
          w_state = S_STOP;
          w_baud  = 8'd0;
          w_txd   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        w_txd = 1'b1;
        if (w_last) begin
          w_state = S_IDLE;
          w_baud  = 8'd0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_baud  = 8'd0;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      r_state <= S_IDLE;
      r_baud  <= 8'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_txd   <= w_txd;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign txd  = r_txd;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_io_serializer.sv
// tb_io_serializer: randomized scoreboard bench for io_serializer.
// Stimulus pushes the expected frame (as a per-bit level vector) when it loads a word;
// a negedge monitor pops and compares every frame cycle, the done cycle and idle cycles.
module tb_io_serializer;
  localparam int C = 4;
`ifdef IO_SERIALIZER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * C;

  logic       clk = 1'b0;
  logic       rs  = 1'b1;
  logic       ld  = 1'b0;
  logic       g2b = 1'b0;
  logic [7:0] din = 8'h00;
  logic       txd, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [10:0] exp_q[$];
  logic [10:0] cur = '1;
  bit          in_frame   = 1'b0;
  bit          abort_next = 1'b0;
  bit          mon_en     = 1'b0;
  int          cyc        = 0;

  io_serializer #(.CLKS_PER_BIT(C)) dut (
    .clk (clk),
    .rs  (rs),
    .din (din),
    .ld  (ld),
    .g2b (g2b),
    .txd (txd),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference frame: bit k of the result is the line level during bit period k.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic g);
    logic [7:0]  b;
    logic [10:0] f;
    b = d;
    if (g) begin
      for (int k = 1; k < 8; k++) b = b ^ (d >> k);
    end
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1 + k] = b[k];
`ifdef IO_SERIALIZER_PARITY_EN
    f[9] = ($countones(b) % 2) == 1;
`endif
    return f;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (abort_next) begin
        check("abort_txd",  txd,  1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        in_frame   = 1'b0;
        abort_next = 1'b0;
      end else if (in_frame) begin
        if (cyc < FRAME_CYC) begin
          check($sformatf("frame_txd[c%0d]", cyc), txd, cur[cyc / C]);
          check("frame_busy", busy, 1'b1);
          check("frame_done", done, 1'b0);
          cyc++;
        end else begin
          check("end_busy", busy, 1'b0);
          check("end_done", done, 1'b1);
          check("end_txd",  txd,  1'b1);
          in_frame = 1'b0;
        end
      end else if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_frame: busy=1 expected busy=0 at %0t", $time);
        end else begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          check("frame_txd[c0]", txd, cur[0]);
          check("frame_done", done, 1'b0);
          cyc = 1;
        end
      end else begin
        check("idle_txd",  txd,  1'b1);
        check("idle_done", done, 1'b0);
      end
      if (rs) abort_next = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 1000) begin
      tick();
      t++;
    end
    if (t >= 1000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b expected 0 within 1000 cycles", busy);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic g);
    wait_idle();
    din = d;
    g2b = g;
    ld  = 1'b1;
    exp_q.push_back(model_frame(d, g));
    tick();
    ld  = 1'b0;
    din = 8'($urandom);
    g2b = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_txd",  txd,  1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rs     = 1'b0;
    mon_en = 1'b1;
    tick();

    // Directed frames: plain, Gray, parity-relevant words
    send(8'hA5, 1'b0);
    send(8'h0F, 1'b1);
    send(8'h07, 1'b0);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b1);

    // Randomized frames, some with an ignored mid-frame load carrying junk data
    for (int n = 0; n < 20; n++) begin
      send(8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, FRAME_CYC - 4)) tick();
        din = 8'($urandom);
        g2b = 1'($urandom_range(0, 1));
        ld  = 1'b1;
        tick();
        ld  = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    // Back-to-back with ld held; din changes mid-frame
    wait_idle();
    ld  = 1'b1;
    din = 8'h3C;
    g2b = 1'b0;
    exp_q.push_back(model_frame(8'h3C, 1'b0));
    for (int n = 1; n <= FRAME_CYC + 2; n++) begin
      tick();
      if (n == 20) din = 8'hFF;
      if (n == FRAME_CYC + 1) begin
        check("b2b_done", done, 1'b1);
        check("b2b_gap_txd", txd, 1'b1);
        check("b2b_gap_busy", busy, 1'b0);
        exp_q.push_back(model_frame(din, 1'b0));
      end
      if (n == FRAME_CYC + 2) begin
        check("b2b_restart_busy", busy, 1'b1);
        check("b2b_restart_txd", txd, 1'b0);
        ld = 1'b0;
      end
    end

    // Reset mid-frame at cycle 15, then a fresh frame
    send(8'hA5, 1'b0);
    repeat (14) tick();
    rs = 1'b1;
    tick();
    rs = 1'b0;
    check("abort_busy_now", busy, 1'b0);
    check("abort_txd_now",  txd,  1'b1);
    repeat (FRAME_CYC + 4) tick();
    send(8'hA5, 1'b0);

    // Reset and load in the same cycle: load discarded
    wait_idle();
    rs  = 1'b1;
    ld  = 1'b1;
    din = 8'h55;
    tick();
    rs = 1'b0;
    ld = 1'b0;
    repeat (3) tick();
    check("rs_over_ld_busy", busy, 1'b0);

    wait_idle();
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size() == 0, 1'b1);
    check("monitor_idle", in_frame, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
